// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_t  : sequencer state (RUN, MDU_BUSY)
//   NOP_INSN : encoding loaded into bubble-capable pipeline registers
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  // sll $0,$0,0 -- the all-zero word is the canonical NOP
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk : clock
//   clr : synchronous clear (wins over inc)
//   inc : count one event this cycle
//   cnt : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Inputs : clk, rst (sync, active-high), ID source specifiers and use flags,
//          id_jump, EX load info (ex_mem_read, ex_rt), ex_branch_taken,
//          ex_mdu_start.
// Outputs: pc_write, IF/ID hold/flush, ID/EX hold/bubble, EX/MEM bubble,
//          mdu_busy (all combinational from state and inputs), plus
//          saturating stall_cnt / flush_cnt performance counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 8,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  output logic             pc_write,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LW = $clog2(MDU_LATENCY + 1);

  state_t        state;
  logic [LW-1:0] mdu_left;
  logic          lu;
  logic          flush_ev;

  // $zero never creates a hazard, so a load to r0 is not checked
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

  always_comb begin
    pc_write      = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_busy      = 1'b0;
    flush_ev      = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state == MDU_BUSY || ex_mdu_start && !ex_branch_taken) begin
      // freeze the front end and ID/EX; EX/MEM sees NOPs until the result lands
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_bubble = 1'b1;
      mdu_busy      = 1'b1;
    end else if (ex_branch_taken) begin
      pc_write     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_ev     = 1'b1;
    end else if (lu) begin
      // the load leaves EX next cycle, so this clears on its own; a jump
      // sitting in ID waits and is flushed/counted on the following cycle
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (id_jump) begin
      pc_write    = 1'b1;
      if_id_flush = 1'b1;
      flush_ev    = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // the start cycle is the first of MDU_LATENCY stall cycles; MDU_BUSY
  // covers the remaining MDU_LATENCY-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      mdu_left <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mdu_start && !ex_branch_taken) begin
            mdu_left <= LW'(MDU_LATENCY - 1);
            if (MDU_LATENCY > 1)
              state <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          mdu_left <= mdu_left - 1'b1;
          if (mdu_left == LW'(1))
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (!pc_write),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_ev),
    .cnt (flush_cnt)
  );

endmodule
